// File: rtl/spi_master_ctrl.sv
// SPI master: one DATA_WIDTH-bit frame per accepted host word, all four CPOL/CPHA
// modes and both bit orders, sclk half-period of CLK_DIV pclk cycles.
`timescale 1ns/1ps
module spi_master_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic                  pclk,
  input  logic                  areset_n,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  msb_first,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int DCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int ECW = $clog2(2*DATA_WIDTH+1);
  localparam logic [DCW-1:0] DIV_RELOAD = DCW'(CLK_DIV-1);
  localparam logic [ECW-1:0] LAST_EDGE  = ECW'(2*DATA_WIDTH-1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  state_t state, state_nxt;

  logic [DCW-1:0]        div_cnt;
  logic [ECW-1:0]        edge_cnt;
  logic                  cpha_q, msb_q, cfg_seen;
  logic [DATA_WIDTH-1:0] tx_sh, rx_sh;
  logic                  accept, tick, last_edge, odd_edge, sample_edge, drive_edge;

  function automatic logic head(input logic [DATA_WIDTH-1:0] d, input logic msb);
    return msb ? d[DATA_WIDTH-1] : d[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] d,
                                                    input logic msb);
    return msb ? {d[DATA_WIDTH-2:0], 1'b0} : {1'b0, d[DATA_WIDTH-1:1]};
  endfunction

  assign tick        = (div_cnt == '0);
  assign accept      = (state == IDLE) && tx_valid && tx_ready;
  assign last_edge   = (edge_cnt == LAST_EDGE);
  // edge_cnt counts toggles already made, so the upcoming edge number is edge_cnt+1
  assign odd_edge    = ~edge_cnt[0];
  assign sample_edge = odd_edge ^ cpha_q;
  assign drive_edge  = cpha_q ? odd_edge : (~odd_edge && ~last_edge);
  assign busy        = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)            state_nxt = SETUP;
      SETUP:   if (tick)              state_nxt = SHIFT;
      SHIFT:   if (tick && last_edge) state_nxt = HOLD;
      HOLD:    if (tick)              state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge areset_n) begin
    if (!areset_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_ff @(posedge pclk or negedge areset_n) begin
    if (!areset_n) begin
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
      div_cnt  <= '0;
      edge_cnt <= '0;
      cpha_q   <= 1'b0;
      msb_q    <= 1'b0;
      cfg_seen <= 1'b0;
      tx_sh    <= '0;
      rx_sh    <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (state != IDLE) div_cnt <= tick ? DIV_RELOAD : div_cnt - DCW'(1);
      case (state)
        IDLE: begin
          tx_ready <= 1'b1;
          mosi     <= 1'b0;
          // idle level tracks the live cpol until a frame has latched one
          if (!cfg_seen) sclk <= cpol;
          if (accept) begin
            tx_ready <= 1'b0;
            cs_n     <= 1'b0;
            sclk     <= cpol;
            cpha_q   <= cpha;
            msb_q    <= msb_first;
            cfg_seen <= 1'b1;
            div_cnt  <= DIV_RELOAD;
            edge_cnt <= '0;
            rx_sh    <= '0;
            if (!cpha) begin
              mosi  <= head(tx_data, msb_first);
              tx_sh <= advance(tx_data, msb_first);
            end else begin
              tx_sh <= tx_data;
            end
          end
        end
        SHIFT: if (tick) begin
          sclk     <= ~sclk;
          edge_cnt <= edge_cnt + ECW'(1);
          if (sample_edge)
            rx_sh <= msb_q ? {rx_sh[DATA_WIDTH-2:0], miso} : {miso, rx_sh[DATA_WIDTH-1:1]};
          if (drive_edge) begin
            mosi  <= head(tx_sh, msb_q);
            tx_sh <= advance(tx_sh, msb_q);
          end
        end
        HOLD: if (tick) begin
          cs_n     <= 1'b1;
          tx_ready <= 1'b1;
          rx_valid <= 1'b1;
          rx_data  <= rx_sh;
          mosi     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: DIV=2 and DIV=1 instances, a behavioural SPI
// slave, and a scoreboard queue of expected rx words checked on every rx_valid.
`timescale 1ns/1ps
module tb_spi_master_ctrl;
  logic       pclk = 0, areset_n = 0;
  logic       cpol = 1, cpha = 1, msb_first = 1;
  logic       tx_valid0 = 0, tx_valid1 = 0;
  logic [7:0] tx_data = 0;
  logic       tx_ready0, rx_valid0, busy0, sclk0, cs_n0, mosi0, miso0;
  logic       tx_ready1, rx_valid1, busy1, sclk1, cs_n1, mosi1, miso1;
  logic [7:0] rx_data0, rx_data1;
  logic       loop = 0, sel = 0, sl_miso = 0;
  logic [7:0] sl_tx = 0, sl_rx = 0, sl_sh = 0;
  int         sl_edge = 0;
  logic       prev_cs = 1, prev_sclk = 0;
  logic       s_sclk, s_cs, s_mosi, s_rdy, s_rxv;
  int         errors = 0, checks = 0, cyc = 0, rxv_cnt = 0;
  logic [7:0] sb[$];

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  assign miso0  = loop ? mosi0 : sl_miso;
  assign miso1  = sl_miso;
  assign s_sclk = sel ? sclk1 : sclk0;
  assign s_cs   = sel ? cs_n1 : cs_n0;
  assign s_mosi = sel ? mosi1 : mosi0;
  assign s_rdy  = sel ? tx_ready1 : tx_ready0;
  assign s_rxv  = sel ? rx_valid1 : rx_valid0;

  spi_master_ctrl #(.DATA_WIDTH(8), .CLK_DIV(2)) dut0 (
    .pclk(pclk), .areset_n(areset_n), .cpol(cpol), .cpha(cpha), .msb_first(msb_first),
    .tx_valid(tx_valid0), .tx_ready(tx_ready0), .tx_data(tx_data),
    .rx_valid(rx_valid0), .rx_data(rx_data0), .busy(busy0),
    .sclk(sclk0), .cs_n(cs_n0), .mosi(mosi0), .miso(miso0));

  spi_master_ctrl #(.DATA_WIDTH(8), .CLK_DIV(1)) dut1 (
    .pclk(pclk), .areset_n(areset_n), .cpol(cpol), .cpha(cpha), .msb_first(msb_first),
    .tx_valid(tx_valid1), .tx_ready(tx_ready1), .tx_data(tx_data),
    .rx_valid(rx_valid1), .rx_data(rx_data1), .busy(busy1),
    .sclk(sclk1), .cs_n(cs_n1), .mosi(mosi1), .miso(miso1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // MSB-first slave, observed on the falling pclk edge so it never races the DUT
  always @(negedge pclk) begin
    if (!s_cs && prev_cs) begin
      sl_edge = 0;
      sl_rx   = 0;
      sl_sh   = sl_tx;
      if (!cpha) begin sl_miso = sl_sh[7]; sl_sh = {sl_sh[6:0], 1'b0}; end
    end else if (!s_cs && s_sclk !== prev_sclk) begin
      sl_edge++;
      if (((sl_edge % 2) == 1) != cpha) sl_rx = {sl_rx[6:0], s_mosi};
      else begin sl_miso = sl_sh[7]; sl_sh = {sl_sh[6:0], 1'b0}; end
    end
    prev_cs   = s_cs;
    prev_sclk = s_sclk;
  end

  always @(negedge pclk) begin
    if (rx_valid0 || rx_valid1) begin
      rxv_cnt++;
      if (sb.size() == 0) chk("sb_unexpected_rx", sb.size(), 1);
      else chk("sb_rx_data", rx_valid1 ? rx_data1 : rx_data0, sb.pop_front());
    end
  end

  task automatic run(input logic which, input logic [7:0] d, input logic [7:0] exp_rx,
                     output int lat, output int cs_low, output int edges,
                     output logic [7:0] odd_mosi);
    int t0, n;
    logic prev, got;
    sel = which; lat = -1; cs_low = 0; edges = 0; odd_mosi = 0; got = 0;
    sb.push_back(exp_rx);
    @(negedge pclk);
    tx_data = d;
    if (which) tx_valid1 = 1; else tx_valid0 = 1;
    n = 0;
    while (!s_rdy && n < 50) begin @(negedge pclk); n++; end
    chk("accept_ready", s_rdy, 1);
    @(negedge pclk);
    tx_valid0 = 0; tx_valid1 = 0;
    t0 = cyc; prev = s_sclk;
    for (int i = 0; i < 400; i++) begin
      if (s_rxv) begin got = 1; lat = cyc - t0; break; end
      if (!s_cs) cs_low++;
      if (s_sclk !== prev) begin
        edges++;
        prev = s_sclk;
        if ((edges % 2) == 1 && edges <= 15) odd_mosi[(edges-1)/2] = s_mosi;
      end
      @(negedge pclk);
    end
    chk("rx_valid_seen", got, 1);
    @(negedge pclk);
    chk("rx_valid_one_cycle", s_rxv, 0);
  endtask

  initial begin
    int lat, csl, edg, k, e, base;
    logic [7:0] om;
    logic prv;
    #1;
    @(negedge pclk);
    chk("rst_tx_ready", tx_ready0, 0);
    chk("rst_rx_valid", rx_valid0, 0);
    chk("rst_rx_data", rx_data0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_sclk", sclk0, 0);
    chk("rst_cs_n", cs_n0, 1);
    chk("rst_mosi", mosi0, 0);
    areset_n = 1;
    repeat (3) @(negedge pclk);
    chk("idle_tx_ready", tx_ready0, 1);
    chk("idle_sclk_cpol", sclk0, 1);

    // mode 3 against the slave
    loop = 0; sl_tx = 8'h3C;
    run(0, 8'hC3, 8'h3C, lat, csl, edg, om);
    chk("m3_slave_rx", sl_rx, 8'hC3);
    chk("m3_sclk_idle_after", sclk0, 1);
    chk("m3_edges", edg, 16);

    // mode 0 loopback, timing
    cpol = 0; cpha = 0; loop = 1;
    run(0, 8'hA5, 8'hA5, lat, csl, edg, om);
    chk("m0_latency", lat, 36);
    chk("m0_cs_low", csl, 36);
    chk("m0_edges", edg, 16);
    chk("m0_sclk_idle", sclk0, 0);

    // mode 1, lsb first
    cpha = 1; msb_first = 0;
    run(0, 8'h01, 8'h01, lat, csl, edg, om);
    chk("lsb_driven_bits", om, 8'h01);

    // back-to-back frames with tx_valid held
    cpha = 0; msb_first = 1; sel = 0;
    sb.push_back(8'h11); sb.push_back(8'h22);
    base = rxv_cnt;
    @(negedge pclk);
    tx_data = 8'h11; tx_valid0 = 1;
    k = 0;
    while (!tx_ready0 && k < 50) begin @(negedge pclk); k++; end
    @(negedge pclk);
    tx_data = 8'h22;
    k = 0;
    while (!rx_valid0 && k < 100) begin @(negedge pclk); k++; end
    chk("b2b_first_rx", rx_valid0, 1);
    chk("b2b_cs_high", cs_n0, 1);
    @(negedge pclk);
    chk("b2b_gap_one", cs_n0, 0);
    tx_valid0 = 0;
    k = 0;
    while (!rx_valid0 && k < 100) begin @(negedge pclk); k++; end
    chk("b2b_second_rx", rx_valid0, 1);
    @(negedge pclk);
    chk("b2b_pulses", rxv_cnt - base, 2);

    // reset at sclk edge 7
    base = rxv_cnt;
    @(negedge pclk);
    tx_data = 8'h77; tx_valid0 = 1;
    k = 0;
    while (!tx_ready0 && k < 50) begin @(negedge pclk); k++; end
    @(negedge pclk);
    tx_valid0 = 0; prv = sclk0; e = 0;
    for (int i = 0; i < 100; i++) begin
      if (sclk0 !== prv) begin e++; prv = sclk0; end
      if (e == 7) break;
      @(negedge pclk);
    end
    chk("rst_mid_edges", e, 7);
    #2 areset_n = 0;
    #1;
    chk("rst_mid_cs_n", cs_n0, 1);
    chk("rst_mid_busy", busy0, 0);
    chk("rst_mid_rx_data", rx_data0, 0);
    chk("rst_mid_tx_ready", tx_ready0, 0);
    repeat (2) @(negedge pclk);
    areset_n = 1;
    repeat (3) @(negedge pclk);
    chk("rst_mid_no_rx_valid", rxv_cnt - base, 0);
    run(0, 8'h5A, 8'h5A, lat, csl, edg, om);
    chk("post_rst_latency", lat, 36);

    // DIV=1, mode 2
    cpol = 1; cpha = 0; msb_first = 1; loop = 0; sl_tx = 8'h96;
    repeat (2) @(negedge pclk);
    run(1, 8'hFF, 8'h96, lat, csl, edg, om);
    chk("div1_latency", lat, 18);
    chk("div1_edges", edg, 16);
    chk("div1_cs_low", csl, 18);
    chk("div1_slave_rx", sl_rx, 8'hFF);
    chk("div1_sclk_idle", sclk1, 1);

    repeat (3) @(negedge pclk);
    chk("sb_drained", sb.size(), 0);
    chk("rx_valid_total", rxv_cnt, 7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Synthesizable SPI master controller that sits directly upstream of the slave agent BFM. It drives `sclk`, `cs_n` and `mosi` onto `spi_if`, samples `miso` returned by the slave, and exposes a valid/ready word interface to a host. It supports all four CPOL/CPHA modes and both bit orders, and runs one frame of `DATA_WIDTH` bits per transfer. The bench uses it as the real DUT the slave BFM responds to.

## Interface
Parameters:
- `DATA_WIDTH`, 8: bits per frame (≥2).
- `CLK_DIV`, 2: sclk half-period in `pclk` cycles (≥1); written DIV below.

Ports:
- `pclk` input 1: system clock; all logic is on the rising edge.
- `areset_n` input 1: reset, asynchronous and active-low.
- `cpol` input 1: sclk idle level; latched at frame accept.
- `cpha` input 1: 0 = sample on the leading edge, 1 = sample on the trailing edge; latched at accept.
- `msb_first` input 1: bit order; latched at accept.
- `tx_valid` input 1: host has a word to send.
- `tx_ready` output 1: controller can accept a word.
- `tx_data` input DATA_WIDTH: word to transmit.
- `rx_valid` output 1: one-cycle pulse; `rx_data` is valid.
- `rx_data` output DATA_WIDTH: received word, held until the next frame completes.
- `busy` output 1: high in every non-IDLE state.
- `sclk` output 1: SPI clock to `spi_if`.
- `cs_n` output 1: active-low chip select.
- `mosi` output 1: master-out data.
- `miso` input 1: slave-in data.

## Operation
- Reset values: `tx_ready`=0 while reset is asserted and 1 in IDLE after release. `rx_valid`=0, `rx_data`=0, `busy`=0, `sclk`=0, `cs_n`=1, `mosi`=0.
- Reset mid-frame returns the controller to IDLE immediately. `cs_n` goes to 1 asynchronously, no `rx_valid` is issued, and `rx_data` is cleared.
- Acceptance: a word is accepted when `tx_valid && tx_ready` on a clock edge. At that edge `tx_data`, `cpol`, `cpha` and `msb_first` are latched. Input changes during a frame are ignored.
- IDLE: `tx_ready`=1, `cs_n`=1, `sclk`=latched cpol (the live `cpol` before the first frame), `mosi`=0.
- SETUP (DIV cycles): `cs_n`=0 and `sclk` stays at idle level. If cpha=0, `mosi` presents the first bit for the whole of SETUP.
- SHIFT: `sclk` toggles every DIV cycles, giving exactly 2·DATA_WIDTH edges; the last edge returns `sclk` to cpol.
  - cpha=0: sample `miso` on odd edges (leading); drive the next bit on even edges, except after the final edge.
  - cpha=1: drive a bit on odd edges; sample on even edges.
  - `miso` is captured on the `pclk` edge where the `sclk` register makes its sampling transition. There is no synchronizer.
- Bit order: msb_first=1 shifts out bit DATA_WIDTH-1 first and shifts in at the LSB. msb_first=0 mirrors both.
- HOLD (DIV cycles): `cs_n` stays 0 and `sclk` stays idle.
- On leaving HOLD: go to IDLE, `cs_n`→1, `rx_data` updated and `rx_valid`=1 for exactly one cycle.
- Back-to-back frames: `tx_ready` is high only in IDLE, so `cs_n` is high for at least 1 cycle between frames. With `tx_valid` held high, the gap is exactly 1 cycle.
- Mode reconfiguration: `sclk` changes to a new idle level only in IDLE, when `cpol` is latched at accept.

## Timing
- States: IDLE → SETUP → SHIFT → HOLD → IDLE. There are no other transitions except asynchronous reset to IDLE.
- Edge 0 is the accept edge. `cs_n` falls and `busy` rises on edge 0.
- The first `sclk` edge occurs at edge 2·DIV, then every DIV cycles.
- The last `sclk` edge occurs at edge (2·DATA_WIDTH+1)·DIV.
- `rx_valid` is high in the cycle after edge (2·DATA_WIDTH+2)·DIV. For example, DATA_WIDTH=8 and DIV=2 gives edge 36, so `rx_valid` is high in cycle 37.
- `cs_n` rises on the same edge that asserts `rx_valid`.
- `tx_ready` is asserted on that same edge. The next accept can occur on the following edge.
- Counters: the divider counter is ⌈log2 DIV⌉ bits and reloads to DIV-1. The edge counter is ⌈log2(2·DATA_WIDTH+1)⌉ bits. Neither counter wraps inside a frame.

## Test plan
- Mode 0, DIV=2, `tx_data`=0xA5, `miso` looped to `mosi` → 16 `sclk` edges; `rx_data`=0xA5; `rx_valid` high in cycle 37 after accept; `cs_n` low for 36 cycles.
- Mode 3, slave BFM returns 0x3C, `tx_data`=0xC3 → BFM captures 0xC3; `rx_data`=0x3C; `sclk` idles high before and after the frame.
- msb_first=0, mode 1, `tx_data`=0x01 → first driven `mosi` bit is 1 and the remaining bits are 0; loopback gives `rx_data`=0x01.
- `tx_valid` held high with words 0x11 then 0x22 → two frames; `cs_n` high for exactly 1 cycle between them; two `rx_valid` pulses carrying 0x11 and 0x22.
- `areset_n` pulled low at `sclk` edge 7 of a frame → `cs_n`=1 asynchronously; no `rx_valid`; after release, a new frame with 0x5A completes correctly.
- DIV=1, mode 2, `tx_data`=0xFF → `sclk` toggles every cycle; `rx_valid` in cycle 19; `rx_data` matches `miso` stimulus 0x96.
